// File: rtl/square_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : square_draw_scheduler
// Description : Round-robin sharing of one square rasterizer between drawing
//               clients, emitting clipped pixels over a ready/valid port.
// Revision    : 1.0 - initial release
// ============================================================================
module square_draw_scheduler #(
    parameter int N_REQ    = 4,
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int SIZE_W   = 8,
    parameter int COLOR_W  = 3,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*X_W-1:0]       req_x,
    input  logic [N_REQ*Y_W-1:0]       req_y,
    input  logic [N_REQ*SIZE_W-1:0]    req_size,
    input  logic [N_REQ*COLOR_W-1:0]   req_colour,
    output logic [N_REQ-1:0]           done,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       plot,
    input  logic                       plot_ready,
    output logic [X_W-1:0]             out_x,
    output logic [Y_W-1:0]             out_y,
    output logic [COLOR_W-1:0]         out_colour
);

    localparam int ID_W = $clog2(N_REQ);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_draw = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [X_W:0] c_scr_w = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] c_scr_h = (Y_W+1)'(SCREEN_H);

    logic [1:0]          r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_grant_id;
    logic [X_W-1:0]      r_org_x;
    logic [Y_W-1:0]      r_org_y;
    logic [SIZE_W-1:0]   r_size;
    logic [COLOR_W-1:0]  r_colour;
    logic [SIZE_W-1:0]   r_dx;
    logic [SIZE_W-1:0]   r_dy;
    logic                r_plot;
    logic [X_W-1:0]      r_out_x;
    logic [Y_W-1:0]      r_out_y;
    logic [COLOR_W-1:0]  r_out_colour;
    logic [N_REQ-1:0]    r_done;
    logic                r_busy;

    logic [X_W-1:0]      w_req_x      [N_REQ];
    logic [Y_W-1:0]      w_req_y      [N_REQ];
    logic [SIZE_W-1:0]   w_req_size   [N_REQ];
    logic [COLOR_W-1:0]  w_req_colour [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_req_x[gi]      = req_x[gi*X_W +: X_W];
        assign w_req_y[gi]      = req_y[gi*Y_W +: Y_W];
        assign w_req_size[gi]   = req_size[gi*SIZE_W +: SIZE_W];
        assign w_req_colour[gi] = req_colour[gi*COLOR_W +: COLOR_W];
    end

    // Round-robin pick: first set request at or after r_rr_ptr, wrapping.
    logic             w_pick_found;
    logic [ID_W-1:0]  w_pick;
    logic [ID_W-1:0]  w_scan;

    always_comb begin
        w_pick_found = 1'b0;
        w_pick       = '0;
        w_scan       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
            if (!w_pick_found && req[w_scan]) begin
                w_pick_found = 1'b1;
                w_pick       = w_scan;
            end
        end
    end

    logic w_row_end;
    logic w_last;
    assign w_row_end = (r_dx == r_size - SIZE_W'(1));
    assign w_last    = w_row_end && (r_dy == r_size - SIZE_W'(1));

    // Next-state logic
    logic [1:0] w_state_nxt;
    logic       w_advance;

    always_comb begin
        w_state_nxt = r_state;
        w_advance   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_pick_found) begin
                    w_state_nxt = (w_req_size[w_pick] == '0) ? c_st_done : c_st_draw;
                end
            end
            c_st_draw: begin
                // Clipped pixels are never offered, so they step without a handshake.
                if (!r_plot || plot_ready) begin
                    w_advance = 1'b1;
                    if (w_last) begin
                        w_state_nxt = c_st_done;
                    end
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Output / datapath next values, registered below
    logic [SIZE_W-1:0]   w_dx_nxt;
    logic [SIZE_W-1:0]   w_dy_nxt;
    logic [X_W-1:0]      w_base_x;
    logic [Y_W-1:0]      w_base_y;
    logic [COLOR_W-1:0]  w_src_colour;
    logic [X_W:0]        w_cand_x;
    logic [Y_W:0]        w_cand_y;
    logic                w_on_screen;
    logic                w_plot_nxt;
    logic [X_W-1:0]      w_out_x_nxt;
    logic [Y_W-1:0]      w_out_y_nxt;
    logic [COLOR_W-1:0]  w_out_colour_nxt;
    logic [N_REQ-1:0]    w_done_nxt;
    logic [ID_W-1:0]     w_rr_nxt;
    logic [ID_W-1:0]     w_grant_nxt;

    always_comb begin
        w_dx_nxt         = r_dx;
        w_dy_nxt         = r_dy;
        w_base_x         = r_org_x;
        w_base_y         = r_org_y;
        w_src_colour     = r_colour;
        w_plot_nxt       = r_plot;
        w_out_x_nxt      = r_out_x;
        w_out_y_nxt      = r_out_y;
        w_out_colour_nxt = r_out_colour;
        w_done_nxt       = '0;
        w_rr_nxt         = r_rr_ptr;
        w_grant_nxt      = r_grant_id;

        case (r_state)
            c_st_idle: begin
                w_dx_nxt = '0;
                w_dy_nxt = '0;
                if (w_pick_found) begin
                    w_grant_nxt  = w_pick;
                    w_base_x     = w_req_x[w_pick];
                    w_base_y     = w_req_y[w_pick];
                    w_src_colour = w_req_colour[w_pick];
                end
            end
            c_st_draw: begin
                if (w_advance) begin
                    if (w_row_end) begin
                        w_dx_nxt = '0;
                        w_dy_nxt = r_dy + SIZE_W'(1);
                    end else begin
                        w_dx_nxt = r_dx + SIZE_W'(1);
                    end
                end
            end
            c_st_done: begin
                w_rr_nxt = (r_grant_id == ID_W'(N_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);
            end
            default: begin
                w_rr_nxt = r_rr_ptr;
            end
        endcase

        // One extra bit of headroom so origin+offset overflow reads as off-screen.
        w_cand_x    = {1'b0, w_base_x} + (X_W+1)'(w_dx_nxt);
        w_cand_y    = {1'b0, w_base_y} + (Y_W+1)'(w_dy_nxt);
        w_on_screen = (w_cand_x < c_scr_w) && (w_cand_y < c_scr_h);

        if (w_state_nxt == c_st_draw && (r_state != c_st_draw || w_advance)) begin
            w_plot_nxt = w_on_screen;
            if (w_on_screen) begin
                w_out_x_nxt      = w_cand_x[X_W-1:0];
                w_out_y_nxt      = w_cand_y[Y_W-1:0];
                w_out_colour_nxt = w_src_colour;
            end
        end else if (w_state_nxt != c_st_draw) begin
            w_plot_nxt = 1'b0;
        end

        if (w_state_nxt == c_st_done) begin
            w_done_nxt[w_grant_nxt] = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_org_x      <= '0;
            r_org_y      <= '0;
            r_size       <= '0;
            r_colour     <= '0;
            r_dx         <= '0;
            r_dy         <= '0;
            r_plot       <= 1'b0;
            r_out_x      <= '0;
            r_out_y      <= '0;
            r_out_colour <= '0;
            r_done       <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_grant_id <= w_grant_nxt;
            if (r_state == c_st_idle && w_pick_found) begin
                r_org_x  <= w_req_x[w_pick];
                r_org_y  <= w_req_y[w_pick];
                r_size   <= w_req_size[w_pick];
                r_colour <= w_req_colour[w_pick];
            end
            r_dx         <= w_dx_nxt;
            r_dy         <= w_dy_nxt;
            r_plot       <= w_plot_nxt;
            r_out_x      <= w_out_x_nxt;
            r_out_y      <= w_out_y_nxt;
            r_out_colour <= w_out_colour_nxt;
            r_done       <= w_done_nxt;
            r_busy       <= (w_state_nxt != c_st_idle);
        end
    end

    assign done       = r_done;
    assign busy       = r_busy;
    assign grant_id   = r_grant_id;
    assign plot       = r_plot;
    assign out_x      = r_out_x;
    assign out_y      = r_out_y;
    assign out_colour = r_out_colour;

endmodule
`default_nettype wire

// File: tb/tb_square_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_square_draw_scheduler
// Description : Self-checking bench for square_draw_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_square_draw_scheduler;

    localparam int N_REQ   = 4;
    localparam int X_W     = 9;
    localparam int Y_W     = 8;
    localparam int SIZE_W  = 8;
    localparam int COLOR_W = 3;
    localparam int LIMIT   = 3000;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] c;
    } pix_t;

    logic                      clock;
    logic                      reset;
    logic [N_REQ-1:0]          req;
    logic [N_REQ*X_W-1:0]      req_x;
    logic [N_REQ*Y_W-1:0]      req_y;
    logic [N_REQ*SIZE_W-1:0]   req_size;
    logic [N_REQ*COLOR_W-1:0]  req_colour;
    logic [N_REQ-1:0]          done;
    logic                      busy;
    logic [1:0]                grant_id;
    logic                      plot;
    logic                      plot_ready;
    logic [X_W-1:0]            out_x;
    logic [Y_W-1:0]            out_y;
    logic [COLOR_W-1:0]        out_colour;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   busy_cyc = 0;
    int   done_cyc = 0;
    logic prev_busy = 1'b0;
    pix_t got_pix[$];
    pix_t exp_pix[$];
    int   grants[$];
    int   done_log[$];

    square_draw_scheduler dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_size   (req_size),
        .req_colour (req_colour),
        .done       (done),
        .busy       (busy),
        .grant_id   (grant_id),
        .plot       (plot),
        .plot_ready (plot_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_colour (out_colour)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Mid-cycle observer: accepted pixels, grants and done pulses
    always @(negedge clock) begin
        if (!reset) begin
            if (plot && plot_ready) got_pix.push_back(pix_t'({out_x, out_y, out_colour}));
            if (busy && !prev_busy) begin
                grants.push_back(int'(grant_id));
                busy_cyc <= cyc;
            end
            for (int k = 0; k < N_REQ; k++) begin
                if (done[k]) begin
                    done_log.push_back(k);
                    done_cyc <= cyc;
                end
            end
        end
        prev_busy <= busy;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_logs();
        got_pix.delete();
        exp_pix.delete();
        grants.delete();
        done_log.delete();
    endtask

    // Reference: every square pixel in row-major order, keeping visible ones only.
    task automatic add_expected(input int ox, input int oy, input int sz, input int col);
        pix_t p;
        for (int dy = 0; dy < sz; dy++) begin
            for (int dx = 0; dx < sz; dx++) begin
                if (ox + dx < 320 && oy + dy < 240) begin
                    p.x = X_W'(ox + dx);
                    p.y = Y_W'(oy + dy);
                    p.c = COLOR_W'(col);
                    exp_pix.push_back(p);
                end
            end
        end
    endtask

    function automatic int pix_diff();
        int d = 0;
        if (got_pix.size() != exp_pix.size()) d++;
        for (int i = 0; i < got_pix.size() && i < exp_pix.size(); i++) begin
            if (got_pix[i] !== exp_pix[i]) d++;
        end
        return d;
    endfunction

    task automatic set_job(input int id, input int ox, input int oy, input int sz, input int col);
        req_x[id*X_W +: X_W]             = X_W'(ox);
        req_y[id*Y_W +: Y_W]             = Y_W'(oy);
        req_size[id*SIZE_W +: SIZE_W]    = SIZE_W'(sz);
        req_colour[id*COLOR_W +: COLOR_W] = COLOR_W'(col);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic run_job(input int id, input int ox, input int oy, input int sz, input int col,
                           input bit rnd_ready, output bit timed_out);
        int n;
        clear_logs();
        set_job(id, ox, oy, sz, col);
        add_expected(ox, oy, sz, col);
        plot_ready = 1'b1;
        req[id]    = 1'b1;
        n = 0;
        while (done[id] !== 1'b1 && n < LIMIT) begin
            tick();
            n++;
            if (rnd_ready) plot_ready = ($urandom_range(0, 3) != 0);
        end
        timed_out  = (n >= LIMIT);
        req[id]    = 1'b0;
        plot_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = '0;
        repeat (3) tick();
        total++;
        if ({plot, done, busy} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl plot/done/busy got=%b want=0", {plot, done, busy});
        end
        total++;
        if ({grant_id, out_x, out_y, out_colour} !== 22'b0) begin
            bad++;
            $display("FAIL reset_data gid=%0d x=%0d y=%0d c=%0d want all 0", grant_id, out_x, out_y, out_colour);
        end
        reset = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || plot !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle busy=%b plot=%b want 0 0", busy, plot);
        end
    endtask

    task automatic test_single();
        bit to;
        run_job(0, 10, 20, 2, 5, 1'b0, to);
        total++;
        if (to) begin bad++; $display("FAIL single_timeout got=timeout want=done"); end
        total++;
        if (pix_diff() != 0) begin
            bad++;
            $display("FAIL single_pixels got_n=%0d want_n=%0d diffs=%0d", got_pix.size(), exp_pix.size(), pix_diff());
        end
        total++;
        if (done_cyc - busy_cyc != 4) begin
            bad++;
            $display("FAIL single_latency got=%0d want=4", done_cyc - busy_cyc);
        end
        total++;
        if (done_log.size() != 1 || done_log[0] != 0) begin
            bad++;
            $display("FAIL single_done got_n=%0d want one pulse on client 0", done_log.size());
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_backpressure();
        int n;
        clear_logs();
        set_job(0, 10, 20, 2, 5);
        add_expected(10, 20, 2, 5);
        plot_ready = 1'b1;
        req[0]     = 1'b1;
        n = 0;
        while (plot !== 1'b1 && n < 20) begin tick(); n++; end
        tick();
        plot_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            total++;
            if ({out_x, out_y, out_colour, plot} !== {9'd11, 8'd20, 3'd5, 1'b1}) begin
                bad++;
                $display("FAIL bp_hold%0d got=(%0d,%0d,%0d,p%b) want=(11,20,5,p1)", i, out_x, out_y, out_colour, plot);
            end
        end
        plot_ready = 1'b1;
        n = 0;
        while (done[0] !== 1'b1 && n < 50) begin tick(); n++; end
        total++;
        if (n >= 50) begin bad++; $display("FAIL bp_timeout got=timeout want=done"); end
        req[0] = 1'b0;
        tick();
        total++;
        if (pix_diff() != 0) begin
            bad++;
            $display("FAIL bp_pixels got_n=%0d want_n=%0d diffs=%0d", got_pix.size(), exp_pix.size(), pix_diff());
        end
        total++;
        if (done_cyc - busy_cyc != 7) begin
            bad++;
            $display("FAIL bp_draw_cycles got=%0d want=7", done_cyc - busy_cyc);
        end
    endtask

    // Round-robin scenario: mask held, expected order from the arbitration rule.
    task automatic rr_scenario(input logic [N_REQ-1:0] mask, input int jobs, input bit rnd, input string tag);
        int exp_order[$];
        int ptr;
        int n;
        int sz[N_REQ];
        int ox[N_REQ];
        int oy[N_REQ];
        int col[N_REQ];
        int order_bad;
        do_reset();
        clear_logs();
        for (int c = 0; c < N_REQ; c++) begin
            sz[c]  = rnd ? $urandom_range(0, 4) : 1;
            ox[c]  = rnd ? $urandom_range(0, 400) : 5 * c;
            oy[c]  = rnd ? $urandom_range(0, 255) : 7;
            col[c] = rnd ? $urandom_range(0, 7) : c;
            set_job(c, ox[c], oy[c], sz[c], col[c]);
        end
        ptr = 0;
        for (int j = 0; j < jobs; j++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (mask[(ptr + k) % N_REQ]) begin
                    exp_order.push_back((ptr + k) % N_REQ);
                    break;
                end
            end
            add_expected(ox[exp_order[j]], oy[exp_order[j]], sz[exp_order[j]], col[exp_order[j]]);
            ptr = (exp_order[j] + 1) % N_REQ;
        end
        req = mask;
        n = 0;
        while (done_log.size() < jobs && n < LIMIT) begin
            tick();
            n++;
            if (rnd) plot_ready = ($urandom_range(0, 3) != 0);
        end
        req        = '0;
        plot_ready = 1'b1;
        repeat (2) tick();
        total++;
        if (n >= LIMIT) begin bad++; $display("FAIL %s_timeout got=%0d dones want=%0d", tag, done_log.size(), jobs); end
        order_bad = 0;
        for (int j = 0; j < jobs; j++) begin
            if (j >= grants.size() || grants[j] != exp_order[j]) order_bad++;
            if (j >= done_log.size() || done_log[j] != exp_order[j]) order_bad++;
        end
        total++;
        if (order_bad != 0 || grants.size() != jobs || done_log.size() != jobs) begin
            bad++;
            $display("FAIL %s_order got_grants=%0d got_dones=%0d want=%0d order_errors=%0d first_want=%0d",
                     tag, grants.size(), done_log.size(), jobs, order_bad, exp_order[0]);
        end
        total++;
        if (pix_diff() != 0) begin
            bad++;
            $display("FAIL %s_pixels got_n=%0d want_n=%0d diffs=%0d", tag, got_pix.size(), exp_pix.size(), pix_diff());
        end
    endtask

    task automatic test_round_robin();
        logic [N_REQ-1:0] m;
        rr_scenario(4'b1011, 6, 1'b0, "rr_fixed");
        for (int it = 0; it < 3; it++) begin
            m = N_REQ'($urandom_range(1, 15));
            rr_scenario(m, 2 * $countones(m), 1'b1, "rr_random");
        end
    endtask

    task automatic test_clipping();
        bit to;
        run_job(1, 318, 238, 4, 6, 1'b0, to);
        total++;
        if (to || pix_diff() != 0 || exp_pix.size() != 4) begin
            bad++;
            $display("FAIL clip_corner got_n=%0d want_n=4 diffs=%0d to=%b", got_pix.size(), pix_diff(), to);
        end
        total++;
        if (done_cyc - busy_cyc != 16 || done_log.size() != 1 || done_log[0] != 1) begin
            bad++;
            $display("FAIL clip_corner_done cycles=%0d want=16 dones=%0d want=1", done_cyc - busy_cyc, done_log.size());
        end
        run_job(3, 510, 0, 4, 2, 1'b0, to);
        total++;
        if (to || got_pix.size() != 0 || done_log.size() != 1 || done_log[0] != 3) begin
            bad++;
            $display("FAIL clip_wrap got_pixels=%0d want=0 dones=%0d want=1 to=%b", got_pix.size(), done_log.size(), to);
        end
    endtask

    task automatic test_size_zero();
        bit to;
        run_job(2, 30, 30, 0, 1, 1'b0, to);
        total++;
        if (to || got_pix.size() != 0) begin
            bad++;
            $display("FAIL size0_pixels got=%0d want=0 to=%b", got_pix.size(), to);
        end
        total++;
        if (done_cyc != busy_cyc || done_log.size() != 1 || done_log[0] != 2) begin
            bad++;
            $display("FAIL size0_done offset=%0d want=0 dones=%0d want=1", done_cyc - busy_cyc, done_log.size());
        end
    endtask

    task automatic test_random_jobs();
        bit to;
        int errs = 0;
        int ox;
        int oy;
        for (int it = 0; it < 20; it++) begin
            ox = ($urandom_range(0, 1) != 0) ? $urandom_range(300, 330) : $urandom_range(0, 511);
            oy = ($urandom_range(0, 1) != 0) ? $urandom_range(225, 245) : $urandom_range(0, 255);
            run_job($urandom_range(0, 3), ox, oy, $urandom_range(0, 12), $urandom_range(0, 7), 1'b1, to);
            if (to || pix_diff() != 0 || done_log.size() != 1) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL random_jobs got_bad_jobs=%0d want=0", errs); end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_logs();
        set_job(0, 50, 60, 5, 3);
        plot_ready = 1'b1;
        req        = 4'b0001;
        n = 0;
        while (got_pix.size() < 3 && n < 50) begin tick(); n++; end
        reset = 1'b1;
        req   = 4'b0100;
        set_job(2, 100, 100, 2, 6);
        tick();
        total++;
        if ({plot, busy, done} !== 6'b0) begin
            bad++;
            $display("FAIL reset_mid_outputs plot/busy/done got=%b want=0", {plot, busy, done});
        end
        reset = 1'b0;
        clear_logs();
        add_expected(100, 100, 2, 6);
        n = 0;
        while (done[2] !== 1'b1 && n < 100) begin tick(); n++; end
        req = '0;
        tick();
        total++;
        if (n >= 100 || grants.size() < 1 || grants[0] != 2) begin
            bad++;
            $display("FAIL reset_mid_grant got_grants=%0d want first grant client 2", grants.size());
        end
        total++;
        if (pix_diff() != 0 || done_log.size() != 1 || done_log[0] != 2) begin
            bad++;
            $display("FAIL reset_mid_job pixels=%0d want=%0d dones=%0d want=1", got_pix.size(), exp_pix.size(), done_log.size());
        end
    endtask

    initial begin
        reset      = 1'b1;
        req        = '0;
        req_x      = '0;
        req_y      = '0;
        req_size   = '0;
        req_colour = '0;
        plot_ready = 1'b1;
        test_reset();
        test_single();
        test_backpressure();
        test_clipping();
        test_size_zero();
        test_round_robin();
        test_random_jobs();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
